matrix_store: RTL

- Downstream of the UART matrix-entry stage. Captures each completed matrix (dimensions plus packed 5x5 element array) on its store strobe.
- Files matrices into per-dimension buckets: 25 buckets, (m,n) in 1..5 x 1..5, each holding MAX_PER_DIM entries, with oldest-entry replacement.
- Provides a registered read port and a per-bucket count for the display and operation stages.

---
 rtl/matrix_store.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_store.sv
// matrix_store: files completed matrices into 25 (m,n) buckets with oldest-entry replacement.
// Optional element range scan is enabled by defining MATRIX_STORE_RANGE_CHECK_EN.
module matrix_store #(
    parameter int MAX_PER_DIM = 2,
    parameter int ELEM_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 store_en,
    input  logic [3:0]           mat_m,
    input  logic [3:0]           mat_n,
    input  logic [25*ELEM_W-1:0] mat_data_flat,
    input  logic [7:0]           val_min,
    input  logic [7:0]           val_max,
    input  logic                 clear_all,
    input  logic                 rd_req,
    input  logic [3:0]           rd_m,
    input  logic [3:0]           rd_n,
    input  logic [1:0]           rd_idx,
    output logic                 rd_valid,
    output logic                 rd_hit,
    output logic [25*ELEM_W-1:0] rd_data,
    output logic [2:0]           rd_count,
    output logic                 store_busy,
    output logic                 store_ack,
    output logic                 store_err,
    output logic [2:0]           error_type
);
    localparam int              DW    = 25 * ELEM_W;
    localparam int              SW    = (MAX_PER_DIM > 1) ? $clog2(MAX_PER_DIM) : 1;
    localparam logic [2:0]      CMAX  = 3'(MAX_PER_DIM);
    localparam logic [SW-1:0]   WLAST = SW'(MAX_PER_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic dims_ok(input logic [3:0] m, input logic [3:0] n);
        return (m >= 4'd1) && (m <= 4'd5) && (n >= 4'd1) && (n <= 4'd5);
    endfunction

    function automatic logic [4:0] bucket_of(input logic [3:0] m, input logic [3:0] n);
        return ({1'b0, m} - 5'd1) * 5'd5 + ({1'b0, n} - 5'd1);
    endfunction

    state_t        r_state;
    logic [3:0]    r_m;
    logic [3:0]    r_n;
    logic [DW-1:0] r_data;
    logic [2:0]    r_count [0:24];
    logic [SW-1:0] r_wptr  [0:24];
    logic [DW-1:0] r_mem   [0:24][0:MAX_PER_DIM-1];

    logic [4:0]    w_wb;
    logic [4:0]    w_rb;
    logic          w_rd_ok;
    logic [2:0]    w_rcnt;
    logic [SW-1:0] w_rbase;
    logic [2:0]    w_rsum;
    logic [2:0]    w_rwrap;
    logic [SW-1:0] w_rslot;

    assign w_wb = bucket_of(r_m, r_n);
    assign w_rb = bucket_of(rd_m, rd_n);

`ifdef MATRIX_STORE_RANGE_CHECK_EN
    logic              r_scan;
    logic [4:0]        r_k;
    logic [4:0]        w_mn;
    logic [ELEM_W-1:0] w_elem;
    logic              w_elem_bad;

    assign w_mn       = {1'b0, r_m} * {1'b0, r_n};
    assign w_elem     = r_data[32'(r_k) * ELEM_W +: ELEM_W];
    assign w_elem_bad = (32'(w_elem) < 32'(val_min)) || (32'(w_elem) > 32'(val_max));
`else
    logic w_unused_s;
    assign w_unused_s = ^{val_min, val_max};
`endif

    // Capture FSM: latch, validate, then commit; clear_all aborts any capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_m        <= 4'd0;
            r_n        <= 4'd0;
            r_data     <= '0;
            store_busy <= 1'b0;
            store_ack  <= 1'b0;
            store_err  <= 1'b0;
            error_type <= 3'b000;
`ifdef MATRIX_STORE_RANGE_CHECK_EN
            r_scan     <= 1'b0;
            r_k        <= 5'd0;
`endif
        end else begin
            store_ack <= 1'b0;
            store_err <= 1'b0;
            if (clear_all) begin
                r_state    <= S_IDLE;
                store_busy <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (store_en) begin
                            r_m        <= mat_m;
                            r_n        <= mat_n;
                            r_data     <= mat_data_flat;
                            error_type <= 3'b000;
                            r_state    <= S_CHECK;
                            store_busy <= 1'b1;
`ifdef MATRIX_STORE_RANGE_CHECK_EN
                            r_scan     <= 1'b0;
                            r_k        <= 5'd0;
`endif
                        end
                    end
                    S_CHECK: begin
                        if (!dims_ok(r_m, r_n)) begin
                            store_err  <= 1'b1;
                            error_type <= 3'b001;
                            r_state    <= S_IDLE;
                            store_busy <= 1'b0;
`ifdef MATRIX_STORE_RANGE_CHECK_EN
                        end else if (!r_scan) begin
                            r_scan <= 1'b1;
                        end else if (w_elem_bad) begin
                            store_err  <= 1'b1;
                            error_type <= 3'b010;
                            r_state    <= S_IDLE;
                            store_busy <= 1'b0;
                        end else if (r_k == w_mn - 5'd1) begin
                            store_ack <= 1'b1;
                            r_state   <= S_COMMIT;
                        end else begin
                            r_k <= r_k + 5'd1;
`else
                        end else begin
                            store_ack <= 1'b1;
                            r_state   <= S_COMMIT;
`endif
                        end
                    end
                    S_COMMIT: begin
                        r_state    <= S_IDLE;
                        store_busy <= 1'b0;
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        store_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Bucket bookkeeping: the write pointer always names the oldest slot once full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 25; i++) begin
                r_count[i] <= 3'd0;
                r_wptr[i]  <= '0;
            end
        end else if (clear_all) begin
            for (int i = 0; i < 25; i++) begin
                r_count[i] <= 3'd0;
                r_wptr[i]  <= '0;
            end
        end else if (r_state == S_COMMIT) begin
            r_wptr[w_wb] <= (r_wptr[w_wb] == WLAST) ? '0 : r_wptr[w_wb] + SW'(1);
            if (r_count[w_wb] != CMAX) begin
                r_count[w_wb] <= r_count[w_wb] + 3'd1;
            end
        end
    end

    // Entry storage has no reset; occupancy counts decide what is visible.
    always_ff @(posedge clk) begin
        if ((r_state == S_COMMIT) && !clear_all) begin
            r_mem[w_wb][r_wptr[w_wb]] <= r_data;
        end
    end

    // Read address: logical index 0 is the oldest entry in the bucket.
    always_comb begin
        w_rd_ok = 1'b0;
        w_rcnt  = 3'd0;
        w_rbase = '0;
        w_rsum  = 3'd0;
        w_rwrap = 3'd0;
        w_rslot = '0;
        if (dims_ok(rd_m, rd_n)) begin
            w_rcnt  = r_count[w_rb];
            w_rbase = (w_rcnt == CMAX) ? r_wptr[w_rb] : '0;
            w_rsum  = 3'(w_rbase) + {1'b0, rd_idx};
            w_rwrap = (w_rsum >= CMAX) ? (w_rsum - CMAX) : w_rsum;
            w_rslot = w_rwrap[SW-1:0];
            w_rd_ok = ({1'b0, rd_idx} < w_rcnt);
        end else begin
            w_rd_ok = 1'b0;
        end
    end

    // Registered read port; results hold until the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
            rd_count <= 3'd0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (w_rd_ok) begin
                    rd_hit   <= 1'b1;
                    rd_data  <= r_mem[w_rb][w_rslot];
                    rd_count <= w_rcnt;
                end else begin
                    rd_hit   <= 1'b0;
                    rd_data  <= '0;
                    rd_count <= 3'd0;
                end
            end
        end
    end

endmodule
